// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared state encoding and default word width for the byte-to-word packer.
package fifo_pack_pkg;
  typedef enum logic {FILL, HOLD} pack_state_e;
  localparam int WORD_BYTES_DEF = 4;
endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a registered-output FIFO and packs them little-endian into words.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [7:0]              fifo_data,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*WORD_BYTES-1:0] m_data,
  output logic [WORD_BYTES-1:0]   m_keep,
  output logic [15:0]             words_out
);
  localparam int IW = $clog2(WORD_BYTES) + 1;
  localparam logic [IW:0] WB_FULL = (IW+1)'(WORD_BYTES);
  pack_state_e state_q, state_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic inflight_q;
  logic flush_pending_q, flush_pending_d;
  logic [8*WORD_BYTES-1:0] data_q, data_d;
  logic [WORD_BYTES-1:0] keep_q, keep_d;
  logic [15:0] words_q, words_d;
  logic fill;
  assign fill = state_q == FILL;
  // Bytes already popped but not yet landed count against the free lanes.
  assign fifo_rd = rst & fill & !fifo_empty & !flush_pending_q &
                   (({1'b0, byte_idx_q} + (IW+1)'(inflight_q)) < WB_FULL);
  assign m_valid = state_q == HOLD;
  assign m_data = data_q;
  assign m_keep = keep_q;
  assign words_out = words_q;
  always_comb begin
    state_d = state_q;
    byte_idx_d = byte_idx_q;
    flush_pending_d = flush_pending_q | flush;
    data_d = data_q;
    keep_d = keep_q;
    words_d = words_q;
    if (fill) begin
      if (inflight_q) begin
        for (int i = 0; i < WORD_BYTES; i++)
          if (byte_idx_q == IW'(i)) begin
            data_d[8*i +: 8] = fifo_data;
            keep_d[i] = 1'b1;
          end
        byte_idx_d = byte_idx_q + IW'(1);
        state_d = byte_idx_d == IW'(WORD_BYTES) ? HOLD : FILL;
      end else if (flush_pending_q) begin
        state_d = byte_idx_q != '0 ? HOLD : FILL;
        flush_pending_d = flush;
      end
    end else if (m_ready) begin
      state_d = FILL;
      byte_idx_d = '0;
      data_d = '0;
      keep_d = '0;
      words_d = words_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      byte_idx_q <= '0;
      inflight_q <= 1'b0;
      flush_pending_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      inflight_q <= fifo_rd;
      flush_pending_q <= flush_pending_d;
      data_q <= data_d;
      keep_q <= keep_d;
      words_q <= words_d;
    end
  end
endmodule
